// File: rtl/mem_req_issuer_if.sv
// Bundle between the load/store execute side, the memory access stage streams
// and the mem_req_issuer; master is the issuer's view, slave the environment's.
interface mem_req_issuer_if #(
    parameter int MAX_OUTSTANDING = 4
) (
    input logic clk,
    input logic rst
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [31:0]   cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [2:0]    cmd_funct3;
    logic [16:0]   ctrl_data_o;
    logic          axis_m_addr_tvalid;
    logic          axis_m_addr_tready;
    logic [31:0]   axis_m_addr_tdata;
    logic          axis_m_data_tvalid;
    logic          axis_m_data_tready;
    logic [31:0]   axis_m_data_tdata;
    logic          axis_s_data_tvalid;
    logic          axis_s_data_tready;
    logic [31:0]   axis_s_data_tdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic [CW-1:0] outstanding;
    logic [31:0]   dma_shadow;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_funct3,
        input  axis_m_addr_tready, axis_m_data_tready,
        input  axis_s_data_tvalid, axis_s_data_tdata, rsp_ready,
        output cmd_ready, ctrl_data_o,
        output axis_m_addr_tvalid, axis_m_addr_tdata,
        output axis_m_data_tvalid, axis_m_data_tdata,
        output axis_s_data_tready, rsp_valid, rsp_data, outstanding, dma_shadow
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_funct3,
        output axis_m_addr_tready, axis_m_data_tready,
        output axis_s_data_tvalid, axis_s_data_tdata, rsp_ready,
        input  cmd_ready, ctrl_data_o,
        input  axis_m_addr_tvalid, axis_m_addr_tdata,
        input  axis_m_data_tvalid, axis_m_data_tdata,
        input  axis_s_data_tready, rsp_valid, rsp_data, outstanding, dma_shadow
    );

    // A response beat with nothing in flight has no request to belong to.
    a_no_orphan_beat: assert property (@(posedge clk) disable iff (rst)
        !(axis_s_data_tvalid && (outstanding == {CW{1'b0}})))
        else $error("response beat offered with no request in flight");
endinterface

// File: rtl/mem_req_issuer.sv
// Memory-stage initiator: issues load/store commands on the address/data streams
// and returns load data in order. Optional DMA shadow: MEM_REQ_ISSUER_DMA_SHADOW_EN.
module mem_req_issuer #(
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] DMA_ADDR        = 32'h0
) (
    input logic              clk,
    input logic              rst,
    mem_req_issuer_if.master bus
);
    localparam int         CW        = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    logic                       busy_r;
    logic                       addr_sent_r;
    logic                       data_sent_r;
    logic                       wr_r;
    logic [31:0]                addr_r;
    logic [31:0]                wdata_r;
    logic [16:0]                ctrl_r;
    logic [CW-1:0]              outst_r;
    logic [MAX_OUTSTANDING-1:0] tag_r;
    logic [MAX_OUTSTANDING-1:0] tag_n_s;
    logic                       rsp_valid_r;
    logic [31:0]                rsp_data_r;

    logic          addr_hs_s;
    logic          data_hs_s;
    logic          issue_done_s;
    logic          room_s;
    logic          cmd_ready_s;
    logic          accept_s;
    logic          head_store_s;
    logic          s_ready_s;
    logic          beat_s;
    logic [CW-1:0] wr_idx_s;

    function automatic logic [16:0] build_ctrl(input logic write, input logic [2:0] funct3);
        return {7'b0000000, funct3, (write ? OPC_STORE : OPC_LOAD)};
    endfunction

    // Pop shifts the queue toward the head; push lands just past the surviving entries.
    function automatic logic [MAX_OUTSTANDING-1:0] tag_next(
        input logic [MAX_OUTSTANDING-1:0] q,
        input logic                       pop,
        input logic                       push,
        input logic [CW-1:0]              idx,
        input logic                       val
    );
        logic [MAX_OUTSTANDING-1:0] r;
        r = pop ? (q >> 1'b1) : q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r[i] = (push && (idx == CW'(i))) ? val : r[i];
        end
        return r;
    endfunction

    // Handshake, issue-completion and response-acceptance decode.
    always_comb begin
        addr_hs_s    = busy_r && !addr_sent_r && bus.axis_m_addr_tready;
        data_hs_s    = busy_r && !data_sent_r && bus.axis_m_data_tready;
        issue_done_s = busy_r && (addr_sent_r || addr_hs_s) && (data_sent_r || data_hs_s);
        room_s       = (int'(outst_r) + int'(busy_r)) < MAX_OUTSTANDING;
        cmd_ready_s  = !rst && (!busy_r || issue_done_s) && room_s;
        accept_s     = bus.cmd_valid && cmd_ready_s;
        head_store_s = tag_r[0];
        s_ready_s    = !rst && (outst_r != {CW{1'b0}}) &&
                       (head_store_s || !rsp_valid_r || bus.rsp_ready);
        beat_s       = bus.axis_s_data_tvalid && s_ready_s;
        wr_idx_s     = outst_r - CW'(beat_s);
    end

    assign tag_n_s = tag_next(tag_r, beat_s, issue_done_s, wr_idx_s, wr_r);

    // Issue register: captured on accept, freed once both channels have handshaken.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r      <= 1'b0;
            addr_sent_r <= 1'b0;
            data_sent_r <= 1'b0;
            wr_r        <= 1'b0;
            addr_r      <= 32'h0;
            wdata_r     <= 32'h0;
            ctrl_r      <= 17'h0;
        end else if (accept_s) begin
            busy_r      <= 1'b1;
            addr_sent_r <= 1'b0;
            data_sent_r <= 1'b0;
            wr_r        <= bus.cmd_write;
            addr_r      <= bus.cmd_addr;
            wdata_r     <= bus.cmd_write ? bus.cmd_wdata : 32'h0;
            ctrl_r      <= build_ctrl(bus.cmd_write, bus.cmd_funct3);
        end else if (issue_done_s) begin
            busy_r      <= 1'b0;
            addr_sent_r <= 1'b0;
            data_sent_r <= 1'b0;
        end else begin
            addr_sent_r <= addr_sent_r || addr_hs_s;
            data_sent_r <= data_sent_r || data_hs_s;
        end
    end

    // In-flight count and per-request load/store tags, oldest at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            outst_r <= {CW{1'b0}};
            tag_r   <= {MAX_OUTSTANDING{1'b0}};
        end else begin
            outst_r <= outst_r + CW'(issue_done_s) - CW'(beat_s);
            tag_r   <= tag_n_s;
        end
    end

    // Load result holding register; store acknowledgements never reach it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'h0;
        end else if (beat_s && !head_store_s) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= bus.axis_s_data_tdata;
        end else if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

`ifdef MEM_REQ_ISSUER_DMA_SHADOW_EN
    logic [MAX_OUTSTANDING-1:0] dma_tag_r;
    logic [31:0]                shadow_r;

    // Parallel tag marking which in-flight requests target the DMA register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_tag_r <= {MAX_OUTSTANDING{1'b0}};
        end else begin
            dma_tag_r <= tag_next(dma_tag_r, beat_s, issue_done_s, wr_idx_s, addr_r == DMA_ADDR);
        end
    end

    // A store completing issue is younger than any load returning now, so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= 32'h0;
        end else if (issue_done_s && wr_r && (addr_r == DMA_ADDR)) begin
            shadow_r <= wdata_r;
        end else if (beat_s && !head_store_s && dma_tag_r[0]) begin
            shadow_r <= bus.axis_s_data_tdata;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    assign bus.dma_shadow = shadow_r;
`else
    assign bus.dma_shadow = DMA_ADDR & 32'h0;
`endif

    assign bus.cmd_ready          = cmd_ready_s;
    assign bus.ctrl_data_o        = ctrl_r;
    assign bus.axis_m_addr_tvalid = busy_r && !addr_sent_r;
    assign bus.axis_m_addr_tdata  = addr_r;
    assign bus.axis_m_data_tvalid = busy_r && !data_sent_r;
    assign bus.axis_m_data_tdata  = wdata_r;
    assign bus.axis_s_data_tready = s_ready_s;
    assign bus.rsp_valid          = rsp_valid_r;
    assign bus.rsp_data           = rsp_data_r;
    assign bus.outstanding        = outst_r;
endmodule

// File: tb/tb_mem_req_issuer.sv
// Bench for mem_req_issuer: reset, table-driven single transactions, stall and
// full/backpressure sequences, then random traffic against a transaction-count model.
module tb_mem_req_issuer;
    localparam int          MAXO = 4;
    localparam logic [31:0] DMA  = 32'h0;
`ifdef MEM_REQ_ISSUER_DMA_SHADOW_EN
    localparam bit SH_EN = 1'b1;
`else
    localparam bit SH_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_req_issuer_if #(.MAX_OUTSTANDING(MAXO)) bus (.clk(clk), .rst(rst));
    mem_req_issuer #(.MAX_OUTSTANDING(MAXO), .DMA_ADDR(DMA)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: counts of accepted commands, per-channel handshakes and retired beats.
    int          m_acc, m_ahs, m_dhs, m_rsp;
    logic        q_wr[$];
    logic [31:0] q_addr[$];
    logic [31:0] q_wdata[$];
    logic [2:0]  q_f3[$];
    bit          hold_v;
    logic [31:0] hold_d;
    logic [31:0] shadow_m;
    logic [31:0] got_rsp[$];
    bit          last_acc, last_beat;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] mem;
        logic [16:0] e_ctrl;
        logic [31:0] e_dtd;
        logic        e_rv;
        logic [31:0] e_rd;
        logic [31:0] e_sh;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [16:0] exp_ctrl(input logic w, input logic [2:0] f3);
        logic [16:0] c;
        c = 17'h0;
        c[6:0] = w ? 7'b0100011 : 7'b0000011;
        c[9:7] = f3;
        return c;
    endfunction

    function automatic int model_outst();
        return imin(m_ahs, m_dhs) - m_rsp;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_ahs = 0; m_dhs = 0; m_rsp = 0;
        q_wr.delete(); q_addr.delete(); q_wdata.delete(); q_f3.delete();
        hold_v = 1'b0; hold_d = 32'h0; shadow_m = 32'h0;
        last_acc = 1'b0; last_beat = 1'b0;
    endtask

    // Compare every output against the model, then advance the model by this cycle's handshakes.
    task automatic check_cycle();
        int done, outst, pend, done_nx;
        bit av, dv, ahs, dhs, e_crdy, e_srdy, head_st, acc, beat, dlv;
        if (rst) begin
            model_reset();
            return;
        end
        done    = imin(m_ahs, m_dhs);
        outst   = done - m_rsp;
        pend    = m_acc - done;
        av      = m_ahs < m_acc;
        dv      = m_dhs < m_acc;
        ahs     = av && bus.axis_m_addr_tready;
        dhs     = dv && bus.axis_m_data_tready;
        done_nx = imin(m_ahs + int'(ahs), m_dhs + int'(dhs));
        e_crdy  = ((pend == 0) || (done_nx == m_acc)) && ((outst + pend) < MAXO);
        head_st = (outst > 0) ? q_wr[m_rsp] : 1'b0;
        e_srdy  = (outst > 0) && (head_st || !hold_v || bus.rsp_ready);

        chk("cmd_ready", bus.cmd_ready, e_crdy);
        chk("addr_tvalid", bus.axis_m_addr_tvalid, av);
        chk("data_tvalid", bus.axis_m_data_tvalid, dv);
        chk("s_tready", bus.axis_s_data_tready, e_srdy);
        chk("rsp_valid", bus.rsp_valid, hold_v);
        chk("outstanding", bus.outstanding, outst);
        chk("dma_shadow", bus.dma_shadow, shadow_m);
        if (av) chk("addr_tdata", bus.axis_m_addr_tdata, q_addr[m_ahs]);
        if (dv) chk("data_tdata", bus.axis_m_data_tdata, q_wr[m_dhs] ? q_wdata[m_dhs] : 32'h0);
        if (av || dv) chk("ctrl", bus.ctrl_data_o, exp_ctrl(q_wr[m_acc-1], q_f3[m_acc-1]));
        if (hold_v) chk("rsp_data", bus.rsp_data, hold_d);

        acc  = bus.cmd_valid && e_crdy;
        beat = bus.axis_s_data_tvalid && e_srdy;
        dlv  = hold_v && bus.rsp_ready;
        if (dlv) got_rsp.push_back(hold_d);
        if (beat && !head_st) begin
            hold_v = 1'b1;
            hold_d = bus.axis_s_data_tdata;
            if (SH_EN && q_addr[m_rsp] == DMA) shadow_m = bus.axis_s_data_tdata;
        end else if (dlv) begin
            hold_v = 1'b0;
        end
        if (SH_EN && done_nx > done && q_wr[done] && q_addr[done] == DMA) shadow_m = q_wdata[done];
        if (acc) begin
            q_wr.push_back(bus.cmd_write);
            q_addr.push_back(bus.cmd_addr);
            q_wdata.push_back(bus.cmd_wdata);
            q_f3.push_back(bus.cmd_funct3);
        end
        m_ahs += int'(ahs);
        m_dhs += int'(dhs);
        m_rsp += int'(beat);
        m_acc += int'(acc);
        last_acc  = acc;
        last_beat = beat;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0;
        bus.cmd_wdata = 32'h0; bus.cmd_funct3 = 3'd0;
        bus.axis_m_addr_tready = 1'b0; bus.axis_m_data_tready = 1'b0;
        bus.axis_s_data_tvalid = 1'b0; bus.axis_s_data_tdata = 32'h0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a;
        bus.cmd_wdata = d; bus.cmd_funct3 = f;
    endtask

    initial begin
        int cnt, beats;
        vecs[0] = '{1'b0, 32'd4, 32'h55, 3'd2, 32'd0, 17'h00103, 32'd0, 1'b1, 32'd0, 32'd0};
        vecs[1] = '{1'b1, 32'd4, 32'd42, 3'd2, 32'd4, 17'h00123, 32'd42, 1'b0, 32'd0, 32'd0};
        vecs[2] = '{1'b0, 32'd4, 32'hAA, 3'd2, 32'd42, 17'h00103, 32'd0, 1'b1, 32'd42, 32'd0};
        vecs[3] = '{1'b1, 32'd0, 32'd30, 3'd2, 32'd0, 17'h00123, 32'd30, 1'b0, 32'd0,
                    (SH_EN ? 32'd30 : 32'd0)};
        vecs[4] = '{1'b0, 32'd0, 32'h1, 3'd4, 32'd77, 17'h00203, 32'd0, 1'b1, 32'd77,
                    (SH_EN ? 32'd77 : 32'd0)};
        vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 3'd0, 32'd1, 17'h00023, 32'hDEAD_BEEF,
                    1'b0, 32'd0, (SH_EN ? 32'd77 : 32'd0)};

        // Reset held for 10 cycles.
        rst = 1'b1;
        idle_inputs();
        model_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk("rst_addr_tvalid", bus.axis_m_addr_tvalid, 1'b0);
        chk("rst_data_tvalid", bus.axis_m_data_tvalid, 1'b0);
        chk("rst_s_tready", bus.axis_s_data_tready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_outstanding", bus.outstanding, 32'd0);
        chk("rst_dma_shadow", bus.dma_shadow, 32'd0);
        chk("rst_ctrl", bus.ctrl_data_o, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", bus.cmd_ready, 1'b1);

        // Table-driven single transactions.
        for (int k = 0; k < 6; k++) begin
            set_cmd(vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].f3);
            bus.axis_m_addr_tready = 1'b1;
            bus.axis_m_data_tready = 1'b1;
            tick();
            bus.cmd_valid = 1'b0;
            chk("v_ctrl", bus.ctrl_data_o, vecs[k].e_ctrl);
            chk("v_addr_tdata", bus.axis_m_addr_tdata, vecs[k].addr);
            chk("v_data_tdata", bus.axis_m_data_tdata, vecs[k].e_dtd);
            tick();
            chk("v_outst_issued", bus.outstanding, 32'd1);
            bus.axis_s_data_tvalid = 1'b1;
            bus.axis_s_data_tdata  = vecs[k].mem;
            tick();
            bus.axis_s_data_tvalid = 1'b0;
            chk("v_outst_retired", bus.outstanding, 32'd0);
            chk("v_rsp_valid", bus.rsp_valid, vecs[k].e_rv);
            if (vecs[k].e_rv) chk("v_rsp_data", bus.rsp_data, vecs[k].e_rd);
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            chk("v_dma_shadow", bus.dma_shadow, vecs[k].e_sh);
        end

        // Data channel stalled while the address channel completes.
        set_cmd(1'b1, 32'd8, 32'h1234, 3'd2);
        bus.axis_m_addr_tready = 1'b1;
        bus.axis_m_data_tready = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr_tvalid", bus.axis_m_addr_tvalid, 1'b0);
            chk("stall_data_tvalid", bus.axis_m_data_tvalid, 1'b1);
            chk("stall_data_tdata", bus.axis_m_data_tdata, 32'h1234);
            chk("stall_cmd_ready", bus.cmd_ready, 1'b0);
        end
        bus.axis_m_data_tready = 1'b1;
        #1;
        chk("stall_release_cmd_ready", bus.cmd_ready, 1'b1);
        tick();
        chk("stall_done_data_tvalid", bus.axis_m_data_tvalid, 1'b0);
        chk("stall_done_outstanding", bus.outstanding, 32'd1);
        bus.axis_s_data_tvalid = 1'b1;
        bus.axis_s_data_tdata  = 32'h0;
        tick();
        bus.axis_s_data_tvalid = 1'b0;
        chk("stall_ack_rsp_valid", bus.rsp_valid, 1'b0);

        // Fill to MAX_OUTSTANDING, then drain under response backpressure.
        set_cmd(1'b0, 32'h10, 32'h0, 3'd2);
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 4; i++) begin
            tick();
            if (last_acc) cnt++;
            if (cnt == 4) bus.cmd_valid = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        chk("full_accepts", cnt, 32'd4);
        tick();
        chk("full_outstanding", bus.outstanding, 32'd4);
        chk("full_cmd_ready", bus.cmd_ready, 1'b0);
        got_rsp.delete();
        bus.rsp_ready = 1'b0;
        bus.axis_s_data_tvalid = 1'b1;
        bus.axis_s_data_tdata  = 32'd1;
        tick();
        chk("retire1_outstanding", bus.outstanding, 32'd3);
        chk("retire1_cmd_ready", bus.cmd_ready, 1'b1);
        bus.axis_s_data_tdata = 32'd2;
        tick();
        tick();
        bus.rsp_ready = 1'b1;
        beats = 1;
        for (int i = 0; i < 20 && !(beats == 4 && got_rsp.size() == 4); i++) begin
            tick();
            if (last_beat) begin
                beats++;
                if (beats == 4) bus.axis_s_data_tvalid = 1'b0;
                else bus.axis_s_data_tdata = 32'(beats + 1);
            end
        end
        bus.axis_s_data_tvalid = 1'b0;
        chk("drain_rsp_count", got_rsp.size(), 32'd4);
        for (int i = 0; i < 4 && i < got_rsp.size(); i++) chk("drain_rsp_order", got_rsp[i], 32'(i + 1));
        bus.rsp_ready = 1'b0;
        tick();

        // Random traffic with a reset pulse in the middle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) rst = 1'b1;
            if (cyc == 1503) rst = 1'b0;
            if (rst) begin
                idle_inputs();
            end else begin
                if (!bus.cmd_valid || last_acc) begin
                    bus.cmd_valid  = ($urandom_range(0, 3) != 0);
                    bus.cmd_write  = 1'($urandom_range(0, 1));
                    bus.cmd_addr   = 32'($urandom_range(0, 7)) << 2;
                    bus.cmd_wdata  = $urandom;
                    bus.cmd_funct3 = 3'($urandom_range(0, 7));
                end
                bus.axis_m_addr_tready = ($urandom_range(0, 2) != 0);
                bus.axis_m_data_tready = ($urandom_range(0, 2) != 0);
                bus.rsp_ready          = 1'($urandom_range(0, 1));
                if (!(bus.axis_s_data_tvalid && !last_beat)) begin
                    bus.axis_s_data_tvalid = (model_outst() > 0) && ($urandom_range(0, 1) == 1);
                    bus.axis_s_data_tdata  = $urandom;
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_req_issuer.md
Name: mem_req_issuer

Overview:
Initiator side of the memory access stage's AXI-stream interface.
- Accepts load/store commands from the execute side and drives the address and data streams plus the 17-bit control word into the memory access stage.
- Collects the returned data beats in order, forwards load results upstream and discards store acknowledgements.
- Tracks outstanding requests and keeps a shadow of the DMA register at address 0.

Parameters:
MAX_OUTSTANDING, 4, maximum issued-but-unanswered requests; power of two, 1..16
DMA_ADDR, 32'h0, address of the DMA register; used only by the optional shadow

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  upstream command valid
cmd_ready  out  1  upstream command ready
cmd_write  in  1  1 = store, 0 = load
cmd_addr  in  32  byte address
cmd_wdata  in  32  store data; ignored for loads
cmd_funct3  in  3  width/sign code, passed through
ctrl_data_o  out  17  [6:0] opcode (7'b0000011 load, 7'b0100011 store), [9:7] funct3, [16:10] zero
axis_m_addr_tvalid/tready/tdata  out/in/out  1/1/32  address stream to memory stage
axis_m_data_tvalid/tready/tdata  out/in/out  1/1/32  write-data stream to memory stage; tdata is 0 for loads
axis_s_data_tvalid/tready/tdata  in/out/in  1/1/32  response stream from memory stage
rsp_valid  out  1  load result valid
rsp_ready  in  1  load result ready
rsp_data  out  32  load result
outstanding  out  $clog2(MAX_OUTSTANDING)+1  current in-flight count
dma_shadow  out  32  last value stored to DMA_ADDR (see optional feature)

Behaviour:
- Reset values: all outputs 0.
  - This includes cmd_ready, all tvalids, rsp_valid, outstanding, dma_shadow and ctrl_data_o.
  - A reset mid-operation drops the held command, in-flight tags and any pending response.
- Issue register: one entry holding cmd, ctrl word, addr_sent flag and data_sent flag.
- cmd_ready = (issue register empty, or both channels completing this cycle) AND outstanding + pending < MAX_OUTSTANDING.
- A command is accepted on cmd_valid && cmd_ready. Both tvalids rise the next cycle.
- Addr and data channels handshake independently:
  - Each tvalid drops after its own handshake and must not drop before it.
  - tdata and ctrl_data_o stay stable while either tvalid is high.
- Issue completes when both flags are set, or both handshakes occur in the same cycle.
  - On completion, the write bit is pushed into the tag FIFO (depth MAX_OUTSTANDING) and outstanding is incremented.
  - Back-to-back: a new command may be accepted in the cycle the previous one completes (full throughput, 1 command/cycle).
- Response path: axis_s_data_tready = tag FIFO non-empty AND (head is store OR rsp holding register empty OR rsp_ready).
  - On a response beat, the tag is popped and outstanding is decremented.
  - Load head: tdata is registered into rsp_data and rsp_valid=1 the next cycle, held until rsp_ready.
  - Store head: the beat is dropped.
- Issue and retire in the same cycle: outstanding is unchanged.
- A response beat arriving with the tag FIFO empty is not accepted (tready=0). This is a protocol violation and is flagged by a simulation assertion.
- Full: outstanding == MAX_OUTSTANDING forces cmd_ready=0. Counter never exceeds MAX_OUTSTANDING and never wraps.
- Order: strict in-order; responses correspond to issued requests FIFO-wise.
- Latency: command accepted at cycle N gives tvalids at N+1. Response accepted at M gives rsp_valid at M+1.

Optional Feature:
MEM_REQ_ISSUER_DMA_SHADOW_EN
- Defined:
  - dma_shadow captures cmd_wdata when a store to DMA_ADDR completes issue.
  - A load to DMA_ADDR whose response returns updates dma_shadow with the response data.
- Undefined: dma_shadow is tied to 0 and the shadow logic is omitted.

Test Plan:
- Reset: hold rst=1 for 10 cycles, then release → all outputs 0, cmd_ready=1 in the first cycle after release.
- Load addr 4, memory returns 0 → ctrl_data_o[6:0]=7'b0000011, addr tdata=4, data tdata=0, rsp_data=0, outstanding 0→1→0.
- Store 42 to addr 4, then load addr 4, memory returns 4 then 42 → no rsp for the store ack, rsp_data=42 for the load.
- Store 30 to addr 0 (shadow enabled) → dma_shadow=30 after issue. Without the macro, dma_shadow stays 0.
- Stalls: addr tready=1 while data tready is held 0 for 3 cycles → addr tvalid drops after its handshake, data tvalid stays high with stable tdata, cmd_ready=0 until the data handshake.
- Full and backpressure: issue 4 loads with axis_s tvalid=0 → outstanding=4, cmd_ready=0. Return beats 1,2,3,4 with rsp_ready low for 2 cycles → rsp_data in order 1,2,3,4, none lost, cmd_ready returns after the first retire.
